// File: rtl/bsg_axil_store_unpacker_if.sv
// Bundle of the packed command/response streams and the AXI4-Lite master bus.
// The master modport is the unpacker; the slave modport is the environment.
interface bsg_axil_store_unpacker_if #(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32
);
    logic [axil_data_width_p-1:0]   data_i;
    logic                           v_i;
    logic                           ready_o;
    logic [axil_data_width_p-1:0]   data_o;
    logic                           v_o;
    logic                           ready_i;

    logic [axil_addr_width_p-1:0]   m_axil_awaddr_o;
    logic [2:0]                     m_axil_awprot_o;
    logic                           m_axil_awvalid_o;
    logic                           m_axil_awready_i;
    logic [axil_data_width_p-1:0]   m_axil_wdata_o;
    logic [axil_data_width_p/8-1:0] m_axil_wstrb_o;
    logic                           m_axil_wvalid_o;
    logic                           m_axil_wready_i;
    logic [1:0]                     m_axil_bresp_i;
    logic                           m_axil_bvalid_i;
    logic                           m_axil_bready_o;
    logic [axil_addr_width_p-1:0]   m_axil_araddr_o;
    logic [2:0]                     m_axil_arprot_o;
    logic                           m_axil_arvalid_o;
    logic                           m_axil_arready_i;
    logic [axil_data_width_p-1:0]   m_axil_rdata_i;
    logic [1:0]                     m_axil_rresp_i;
    logic                           m_axil_rvalid_i;
    logic                           m_axil_rready_o;

    modport master (
        input  data_i, v_i, ready_i,
        output ready_o, data_o, v_o,
        output m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
        input  m_axil_awready_i,
        output m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
        input  m_axil_wready_i,
        input  m_axil_bresp_i, m_axil_bvalid_i,
        output m_axil_bready_o,
        output m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
        input  m_axil_arready_i,
        input  m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
        output m_axil_rready_o
    );

    modport slave (
        output data_i, v_i, ready_i,
        input  ready_o, data_o, v_o,
        input  m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
        output m_axil_awready_i,
        input  m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
        output m_axil_wready_i,
        output m_axil_bresp_i, m_axil_bvalid_i,
        input  m_axil_bready_o,
        input  m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
        output m_axil_arready_i,
        output m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
        input  m_axil_rready_o
    );
endinterface

// File: rtl/bsg_axil_store_unpacker.sv
// Unpacks {wnr, addr, data} command words into single-outstanding AXI4-Lite
// transactions and returns load data as a response word.
module bsg_axil_store_unpacker #(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int payload_data_width_p = 8,
    parameter logic [axil_addr_width_p-1:0] base_addr_p = '0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_axil_store_unpacker_if.master bus,
    output logic error_o
);
    localparam int dw_lp = axil_data_width_p;
    localparam int pw_lp = payload_data_width_p;
    localparam int strb_w_lp = dw_lp/8;
    localparam int pstrb_w_lp = pw_lp/8;
    localparam logic [strb_w_lp-1:0] wstrb_lp =
        {{(strb_w_lp-pstrb_w_lp){1'b0}}, {pstrb_w_lp{1'b1}}};

    typedef enum logic [2:0] {
        e_ready, e_write, e_write_resp, e_read_req, e_read_resp, e_read_data
    } state_e;

    state_e                       state_r, state_n;
    logic [axil_addr_width_p-1:0] addr_r;
    logic [pw_lp-1:0]             pdata_r;
    logic [dw_lp-1:0]             rdata_r;
    logic                         aw_done_r, w_done_r, error_r;
    logic                         accept, awvalid, wvalid, aw_fire, w_fire, b_fire, r_fire;
    logic                         unused_rdata;

    assign accept  = bus.v_i & (state_r == e_ready);
    assign awvalid = (state_r == e_write) & ~aw_done_r;
    assign wvalid  = (state_r == e_write) & ~w_done_r;
    assign aw_fire = awvalid & bus.m_axil_awready_i;
    assign w_fire  = wvalid & bus.m_axil_wready_i;
    assign b_fire  = (state_r == e_write_resp) & bus.m_axil_bvalid_i;
    assign r_fire  = (state_r == e_read_resp) & bus.m_axil_rvalid_i;
    assign unused_rdata = ^bus.m_axil_rdata_i[dw_lp-1:pw_lp];

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready:      if (bus.v_i) state_n = bus.data_i[dw_lp-1] ? e_write : e_read_req;
            // AW and W may complete in either order or together
            e_write:      if ((aw_done_r | aw_fire) & (w_done_r | w_fire)) state_n = e_write_resp;
            e_write_resp: if (bus.m_axil_bvalid_i) state_n = e_ready;
            e_read_req:   if (bus.m_axil_arready_i) state_n = e_read_resp;
            e_read_resp:  if (bus.m_axil_rvalid_i) state_n = e_read_data;
            e_read_data:  if (bus.ready_i) state_n = e_ready;
            default:      state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_ready;
            addr_r    <= '0;
            pdata_r   <= '0;
            rdata_r   <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                addr_r    <= axil_addr_width_p'(bus.data_i[dw_lp-2:pw_lp]) + base_addr_p;
                pdata_r   <= bus.data_i[pw_lp-1:0];
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end
            if (aw_fire) aw_done_r <= 1'b1;
            if (w_fire)  w_done_r  <= 1'b1;
            if (b_fire && bus.m_axil_bresp_i != 2'b00) error_r <= 1'b1;
            if (r_fire) begin
                rdata_r <= dw_lp'(bus.m_axil_rdata_i[pw_lp-1:0]);
                if (bus.m_axil_rresp_i != 2'b00) error_r <= 1'b1;
            end
        end
    end

    assign bus.ready_o          = (state_r == e_ready);
    assign bus.v_o              = (state_r == e_read_data);
    assign bus.data_o           = (state_r == e_read_data) ? rdata_r : '0;
    assign bus.m_axil_awaddr_o  = addr_r;
    assign bus.m_axil_awprot_o  = 3'b000;
    assign bus.m_axil_awvalid_o = awvalid;
    assign bus.m_axil_wdata_o   = dw_lp'(pdata_r);
    assign bus.m_axil_wstrb_o   = wstrb_lp;
    assign bus.m_axil_wvalid_o  = wvalid;
    assign bus.m_axil_bready_o  = (state_r == e_write_resp);
    assign bus.m_axil_araddr_o  = addr_r;
    assign bus.m_axil_arprot_o  = 3'b000;
    assign bus.m_axil_arvalid_o = (state_r == e_read_req);
    assign bus.m_axil_rready_o  = (state_r == e_read_resp);
    assign error_o              = error_r;
endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// Directed and randomized checks of the store unpacker against an arithmetic
// model of address/data unpacking, handshake timing and sticky error.
module tb_bsg_axil_store_unpacker;
    localparam int A = 32;
    localparam int D = 32;
    localparam int P = 8;
    localparam int PAW = D - P - 1;
    localparam logic [A-1:0] BASE = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic error;
    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    bsg_axil_store_unpacker_if #(.axil_addr_width_p(A), .axil_data_width_p(D)) bus ();

    bsg_axil_store_unpacker #(
        .axil_addr_width_p(A), .axil_data_width_p(D),
        .payload_data_width_p(P), .base_addr_p(BASE)
    ) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus), .error_o(error));

    function automatic logic [A-1:0] m_addr(input logic [D-1:0] cmd);
        longint unsigned f;
        f = (longint'(cmd) / (64'd1 << P)) % (64'd1 << PAW);
        return A'((f + longint'(BASE)) % (64'd1 << A));
    endfunction
    function automatic logic [D-1:0] m_low(input logic [D-1:0] v);
        return D'(longint'(v) % (64'd1 << P));
    endfunction
    function automatic logic [D/8-1:0] m_strb();
        return (D/8)'((1 << (P/8)) - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [D-1:0] cmd, input int ad, input int wd, input int bd,
                            input logic [1:0] resp, input bit hold, input logic [D-1:0] nxt);
        int naw = 0, nw = 0, cyc = 0, mx;
        bit done = 0;
        mx = (ad > wd) ? ad : wd;
        bus.data_i = cmd; bus.v_i = 1'b1;
        chk("w_ready_o_idle", bus.ready_o, 1);
        step();
        bus.v_i = hold; bus.data_i = hold ? nxt : $urandom;
        while ((naw == 0 || nw == 0) && cyc < 60) begin
            chk("awvalid", bus.m_axil_awvalid_o, naw == 0);
            chk("wvalid", bus.m_axil_wvalid_o, nw == 0);
            chk("w_ready_o_busy", bus.ready_o, 0);
            chk("w_v_o", bus.v_o, 0);
            if (naw == 0) begin
                chk("awaddr", bus.m_axil_awaddr_o, m_addr(cmd));
                chk("awprot", bus.m_axil_awprot_o, 0);
            end
            if (nw == 0) begin
                chk("wdata", bus.m_axil_wdata_o, m_low(cmd));
                chk("wstrb", bus.m_axil_wstrb_o, m_strb());
            end
            bus.m_axil_awready_i = (cyc >= ad);
            bus.m_axil_wready_i = (cyc >= wd);
            if (bus.m_axil_awvalid_o && bus.m_axil_awready_i) naw++;
            if (bus.m_axil_wvalid_o && bus.m_axil_wready_i) nw++;
            if (!hold) bus.data_i = $urandom;
            step(); cyc++;
        end
        bus.m_axil_awready_i = 1'b0; bus.m_axil_wready_i = 1'b0;
        chk("aw_count", naw, 1);
        chk("w_count", nw, 1);
        chk("aw_w_cycles", cyc, mx + 1);
        cyc = 0;
        while (!done && cyc < 60) begin
            chk("bready", bus.m_axil_bready_o, 1);
            chk("awvalid_after", bus.m_axil_awvalid_o, 0);
            chk("wvalid_after", bus.m_axil_wvalid_o, 0);
            chk("b_ready_o_busy", bus.ready_o, 0);
            bus.m_axil_bvalid_i = (cyc >= bd);
            bus.m_axil_bresp_i = bus.m_axil_bvalid_i ? resp : 2'b00;
            done = bus.m_axil_bvalid_i;
            step(); cyc++;
        end
        bus.m_axil_bvalid_i = 1'b0; bus.m_axil_bresp_i = 2'b00;
        if (resp != 2'b00) exp_err = 1'b1;
        chk("b_done", done, 1);
        chk("w_error_o", error, exp_err);
        chk("w_ready_o_end", bus.ready_o, 1);
        chk("w_no_resp", bus.v_o, 0);
        chk("bready_end", bus.m_axil_bready_o, 0);
    endtask

    task automatic do_read(input logic [D-1:0] cmd, input int ard, input int rd, input int hd,
                           input logic [D-1:0] rdata, input logic [1:0] resp);
        int cyc = 0;
        bit done = 0;
        bus.data_i = cmd; bus.v_i = 1'b1;
        chk("r_ready_o_idle", bus.ready_o, 1);
        step();
        bus.v_i = 1'b0; bus.data_i = $urandom;
        while (!done && cyc < 60) begin
            chk("arvalid", bus.m_axil_arvalid_o, 1);
            chk("araddr", bus.m_axil_araddr_o, m_addr(cmd));
            chk("arprot", bus.m_axil_arprot_o, 0);
            chk("r_ready_o_busy", bus.ready_o, 0);
            chk("data_o_idle", bus.data_o, 0);
            bus.m_axil_arready_i = (cyc >= ard);
            done = bus.m_axil_arready_i;
            bus.data_i = $urandom;
            step(); cyc++;
        end
        bus.m_axil_arready_i = 1'b0;
        chk("ar_cycles", cyc, ard + 1);
        done = 0; cyc = 0;
        while (!done && cyc < 60) begin
            chk("rready", bus.m_axil_rready_o, 1);
            chk("arvalid_after", bus.m_axil_arvalid_o, 0);
            chk("r_v_o_early", bus.v_o, 0);
            bus.m_axil_rvalid_i = (cyc >= rd);
            bus.m_axil_rdata_i = bus.m_axil_rvalid_i ? rdata : D'($urandom);
            bus.m_axil_rresp_i = bus.m_axil_rvalid_i ? resp : 2'b00;
            done = bus.m_axil_rvalid_i;
            step(); cyc++;
        end
        bus.m_axil_rvalid_i = 1'b0; bus.m_axil_rresp_i = 2'b00; bus.m_axil_rdata_i = $urandom;
        if (resp != 2'b00) exp_err = 1'b1;
        chk("r_cycles", cyc, rd + 1);
        done = 0; cyc = 0;
        while (!done && cyc < 60) begin
            chk("v_o", bus.v_o, 1);
            chk("data_o", bus.data_o, m_low(rdata));
            chk("rready_after", bus.m_axil_rready_o, 0);
            chk("r_error_o", error, exp_err);
            bus.ready_i = (cyc >= hd);
            done = bus.ready_i;
            step(); cyc++;
        end
        bus.ready_i = 1'b0;
        chk("resp_hold_cycles", cyc, hd + 1);
        chk("v_o_cleared", bus.v_o, 0);
        chk("data_o_cleared", bus.data_o, 0);
        chk("r_ready_o_end", bus.ready_o, 1);
    endtask

    initial begin
        logic [D-1:0] cmd;
        bus.data_i = '0; bus.v_i = 1'b0; bus.ready_i = 1'b0;
        bus.m_axil_awready_i = 1'b0; bus.m_axil_wready_i = 1'b0;
        bus.m_axil_bresp_i = 2'b00; bus.m_axil_bvalid_i = 1'b0;
        bus.m_axil_arready_i = 1'b0; bus.m_axil_rdata_i = '0;
        bus.m_axil_rresp_i = 2'b00; bus.m_axil_rvalid_i = 1'b0;
        #13;
        chk("rst_ready_o", bus.ready_o, 1);
        chk("rst_awvalid", bus.m_axil_awvalid_o, 0);
        chk("rst_wvalid", bus.m_axil_wvalid_o, 0);
        chk("rst_arvalid", bus.m_axil_arvalid_o, 0);
        chk("rst_bready", bus.m_axil_bready_o, 0);
        chk("rst_rready", bus.m_axil_rready_o, 0);
        chk("rst_v_o", bus.v_o, 0);
        chk("rst_data_o", bus.data_o, 0);
        chk("rst_error_o", error, 0);
        chk("rst_awaddr", bus.m_axil_awaddr_o, 0);
        #10 rst_n = 1'b1;
        step();

        // minimum-latency write, then read with a stalled response
        do_write(32'h8000_1234, 0, 0, 0, 2'b00, 0, '0);
        chk("ex_awaddr_model", m_addr(32'h8000_1234), 32'h12);
        do_read(32'h0000_5600, 0, 0, 5, 32'hDEAD_BEEF, 2'b00);
        // W completes 3 cycles ahead of AW
        do_write(32'h8ABC_DE5A, 3, 0, 1, 2'b00, 0, '0);
        do_write(32'h8012_3477, 0, 2, 0, 2'b00, 0, '0);
        // back-to-back with v_i held high
        do_write(32'h8000_0A11, 1, 1, 2, 2'b00, 1, 32'h0000_0B00);
        do_read(32'h0000_0B00, 2, 3, 0, 32'h1234_56C3, 2'b00);
        // SLVERR write followed by a normal read
        do_write(32'h8000_0C22, 0, 0, 0, 2'b10, 0, '0);
        do_read(32'h0000_0D00, 0, 0, 1, 32'h0000_0099, 2'b00);

        for (int i = 0; i < 24; i++) begin
            cmd = $urandom;
            if (cmd[D-1])
                do_write(cmd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00, 0, '0);
            else
                do_read(cmd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
        end

        // reset while waiting for R abandons the read
        bus.data_i = 32'h0000_7700; bus.v_i = 1'b1;
        chk("pre_rst_ready_o", bus.ready_o, 1);
        step();
        bus.v_i = 1'b0; bus.m_axil_arready_i = 1'b1;
        chk("pre_rst_arvalid", bus.m_axil_arvalid_o, 1);
        step();
        bus.m_axil_arready_i = 1'b0;
        chk("pre_rst_rready", bus.m_axil_rready_o, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("mid_rst_arvalid", bus.m_axil_arvalid_o, 0);
        chk("mid_rst_rready", bus.m_axil_rready_o, 0);
        chk("mid_rst_v_o", bus.v_o, 0);
        chk("mid_rst_ready_o", bus.ready_o, 1);
        chk("mid_rst_error_o", error, 0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_ready_o", bus.ready_o, 1);
        chk("post_rst_v_o", bus.v_o, 0);
        do_write(32'h8000_4455, 0, 1, 0, 2'b00, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_axil_store_unpacker.md
Name: bsg_axil_store_unpacker

Overview:
- Inverse of the store-packer path.
- Accepts packed command words {write_not_read, addr[payload_addr_width-1:0], data[payload_data_width_p-1:0]} on a valid/ready stream.
- Issues each word as an AXI4-Lite master transaction; returns load data on a valid/ready response stream.
- Sits at the far end of a narrow packed link (e.g. off-chip bridge); drives an AXI-Lite slave fabric; one transaction outstanding at a time.

Parameters:
axil_addr_width_p, 32, AXI-Lite address width
axil_data_width_p, 32, AXI-Lite data width and packed command/response word width
payload_data_width_p, 8, data field width inside a packed word; multiple of 8, less than axil_data_width_p
base_addr_p, 0, axil_addr_width_p-bit constant added to the unpacked address (payload_addr_width = axil_data_width_p - payload_data_width_p - 1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
data_i  in  axil_data_width_p  packed command word
v_i  in  1  command valid
ready_o  out  1  command ready
data_o  out  axil_data_width_p  load response word
v_o  out  1  response valid
ready_i  in  1  response ready
m_axil_awaddr_o  out  axil_addr_width_p  write address
m_axil_awprot_o  out  3  fixed 3'b000
m_axil_awvalid_o / m_axil_awready_i  out/in  1  AW handshake
m_axil_wdata_o  out  axil_data_width_p  write data
m_axil_wstrb_o  out  axil_data_width_p/8  write strobes
m_axil_wvalid_o / m_axil_wready_i  out/in  1  W handshake
m_axil_bresp_i  in  2  write response
m_axil_bvalid_i / m_axil_bready_o  in/out  1  B handshake
m_axil_araddr_o  out  axil_addr_width_p  read address
m_axil_arprot_o  out  3  fixed 3'b000
m_axil_arvalid_o / m_axil_arready_i  out/in  1  AR handshake
m_axil_rdata_i  in  axil_data_width_p  read data
m_axil_rresp_i  in  2  read response
m_axil_rvalid_i / m_axil_rready_o  in/out  1  R handshake
error_o  out  1  sticky: any non-OKAY bresp/rresp seen

Behaviour:
- Reset (reset_n_i low, asynchronous): state e_ready. All valids, bready, rready, v_o, error_o = 0. Command/data registers = 0. Reset mid-transaction abandons it; nothing replays.
- ready_o = (state == e_ready). Command accepted on v_i & ready_o and latched into registers.
- Register fields: wnr = data_i[MSB]; addr = zero-extended addr field + base_addr_p, modulo 2^axil_addr_width_p; pdata = data_i[payload_data_width_p-1:0].
- All AXI and response outputs come from registers and state only; no combinational path from data_i/v_i to any output.
- e_ready: on accept, go to e_write if wnr=1, else e_read_req.
- e_write (first cycle is the one after accept):
  - awvalid = ~aw_done; wvalid = ~w_done; awaddr = addr.
  - wdata = pdata zero-extended; wstrb = low payload_data_width_p/8 bits set (8-bit payload -> 4'b0001).
  - AW and W handshake independently, same cycle or any order; done flags set on each handshake.
  - Once both are done (including both in the same cycle), go to e_write_resp.
- e_write_resp: bready = 1. On bvalid, error_o |= (bresp != OKAY); go to e_ready. Writes produce no response word.
- e_read_req: arvalid = 1, araddr = addr. On arready, go to e_read_resp.
- e_read_resp: rready = 1. On rvalid, latch rdata_r = rdata[payload_data_width_p-1:0] zero-extended; error_o |= (rresp != OKAY); go to e_read_data.
- e_read_data: v_o = 1, data_o = rdata_r, held stable until ready_i. On ready_i, go to e_ready. data_o = 0 in all other states.
- Minimum latency (slave always ready):
  - Write: accept at cycle 0, AW/W at cycle 1, B at cycle 2, ready_o high at cycle 3.
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, v_o at cycle 3.
- Valids never drop before their handshake; addr/data stay stable while valid.
- error_o clears only on reset.

Test Plan:
- Write, slave always ready: data_i=32'h8000_1234 (wnr=1, addr=0x000012, data=0x34), base_addr_p=0 -> awaddr=0x12, wdata=0x34, wstrb=4'b0001, both valid at cycle 1, bready at cycle 2, no v_o, ready_o=1 at cycle 3.
- Read: data_i=32'h0000_5600 (addr=0x56), slave returns rdata=0xDEADBEEF, rresp=OKAY -> araddr=0x56, then v_o=1 with data_o=32'h0000_00EF held under ready_i=0 for 5 cycles, then cleared after ready_i.
- Skewed W/AW: wready high 3 cycles before awready -> wvalid drops after its handshake, awvalid held; exactly one of each handshake; then B accepted.
- Back-to-back commands, v_i held high -> second command accepted only after first completes; ready_o=0 throughout the first transaction.
- bresp=SLVERR on a write, then OKAY read -> error_o rises the cycle after the B handshake and stays 1; the read completes normally.
- Assert reset_n_i while in e_read_resp -> arvalid/rready/v_o go to 0 immediately; after release, ready_o=1 and a new write completes.
